// File: rtl/fetch_pkg.sv
// ============================================================================
// Module  : fetch_pkg
// Purpose : Shared defaults, constants and entry type for the fetch stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;
   localparam int FETCH_AW    = 32;
   localparam int FETCH_ILEN  = 32;
   localparam int INSTR_BYTES = 4;

   typedef struct packed {
      logic [FETCH_AW-1:0]   pc;
      logic [FETCH_ILEN-1:0] instr;
   } fetch_entry_t;
endpackage

`default_nettype wire

// File: rtl/fetch_queue_sync_fifo.sv
// ============================================================================
// Module  : sync_fifo
// Purpose : Single-clock FIFO; simultaneous push/pop allowed when full or empty.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   clear,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout
);
   localparam int c_aw = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_aw-1:0]  r_rd_ptr;
   logic [c_aw-1:0]  r_wr_ptr;
   logic [c_aw:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   always_comb begin
      empty     = (r_count == '0);
      full      = (r_count == (c_aw+1)'(DEPTH));
      count     = r_count;
      w_do_pop  = pop && !empty;
      // A full FIFO still accepts a push when the head leaves in the same cycle
      w_do_push = push && (!full || w_do_pop);
      dout      = empty ? '0 : r_mem[r_rd_ptr];
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
         r_count <= r_count + (c_aw+1)'(w_do_push) - (c_aw+1)'(w_do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= din;
   end
endmodule

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module  : fetch_queue
// Purpose : In-order instruction fetch with PC tagging, decode buffer, redirect.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue
   import fetch_pkg::*;
#(
   parameter int            AW       = FETCH_AW,
   parameter int            ILEN     = FETCH_ILEN,
   parameter int            DEPTH    = 4,
   parameter logic [AW-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect,
   input  logic [AW-1:0]   redirect_pc,
   output logic            imem_req_valid,
   output logic [AW-1:0]   imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_resp_valid,
   input  logic [ILEN-1:0] imem_resp_data,
   output logic            dec_valid,
   output logic [AW-1:0]   dec_pc,
   output logic [ILEN-1:0] dec_instr,
   input  logic            dec_ready
);
   localparam int c_cw = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [AW-1:0]   pc;
      logic [ILEN-1:0] instr;
   } entry_t;

   logic [AW-1:0]   r_fetch_pc;
   logic [c_cw-1:0] r_outstanding;
   logic [c_cw-1:0] r_discard;

   logic [c_cw-1:0] w_out_count;
   logic [c_cw-1:0] w_tag_count;
   logic [c_cw:0]   w_occ;
   logic [c_cw-1:0] w_outst_dec;
   logic [c_cw-1:0] w_outst_after_resp;
   logic            w_req_fire;
   logic            w_resp_keep;
   logic            w_tag_full;
   logic            w_tag_empty;
   logic            w_out_full;
   logic            w_out_empty;
   logic [AW-1:0]   w_tag_dout;
   entry_t          w_out_din;
   entry_t          w_out_dout;
   logic            w_unused;

   always_comb begin
      w_occ              = {1'b0, r_outstanding} + {1'b0, w_out_count};
      imem_req_valid     = !rst && !redirect && (w_occ < (c_cw+1)'(DEPTH));
      imem_req_addr      = r_fetch_pc;
      w_req_fire         = imem_req_valid && imem_req_ready;
      // A response in a redirect cycle is stale by definition
      w_resp_keep        = imem_resp_valid && !redirect && (r_discard == '0);
      w_outst_dec        = (r_outstanding == '0) ? '0 : r_outstanding - c_cw'(1);
      w_outst_after_resp = imem_resp_valid ? w_outst_dec : r_outstanding;
      w_out_din.pc       = w_tag_dout;
      w_out_din.instr    = imem_resp_data;
      dec_valid          = !w_out_empty;
      dec_pc             = w_out_dout.pc;
      dec_instr          = w_out_dout.instr;
      w_unused           = &{1'b0, redirect_pc[1:0], w_tag_full};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_pc    <= RESET_PC;
         r_outstanding <= '0;
         r_discard     <= '0;
      end else if (redirect) begin
         // Every request still in flight is now stale
         r_fetch_pc    <= {redirect_pc[AW-1:2], 2'b00};
         r_outstanding <= w_outst_after_resp;
         r_discard     <= w_outst_after_resp;
      end else begin
         if (w_req_fire) r_fetch_pc <= r_fetch_pc + AW'(INSTR_BYTES);
         if (w_req_fire && !imem_resp_valid && (r_outstanding != {c_cw{1'b1}}))
            r_outstanding <= r_outstanding + c_cw'(1);
         else if (!w_req_fire && imem_resp_valid)
            r_outstanding <= w_outst_dec;
         if (imem_resp_valid && (r_discard != '0))
            r_discard <= r_discard - c_cw'(1);
      end
   end

   sync_fifo #(.WIDTH(AW), .DEPTH(DEPTH)) u_tag_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_req_fire),
      .pop   (w_resp_keep),
      .clear (redirect),
      .full  (w_tag_full),
      .empty (w_tag_empty),
      .count (w_tag_count),
      .din   (r_fetch_pc),
      .dout  (w_tag_dout)
   );

   sync_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_out_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_resp_keep),
      .pop   (dec_ready),
      .clear (redirect),
      .full  (w_out_full),
      .empty (w_out_empty),
      .count (w_out_count),
      .din   (w_out_din),
      .dout  (w_out_dout)
   );

   a_resp_without_request: assert property (@(posedge clk) disable iff (rst)
      !(imem_resp_valid && (r_outstanding == '0)));
   a_tag_available: assert property (@(posedge clk) disable iff (rst)
      !(w_resp_keep && w_tag_empty));
   a_out_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(w_resp_keep && w_out_full && !dec_ready));
   a_tag_tracks_outstanding: assert property (@(posedge clk) disable iff (rst)
      ({1'b0, w_tag_count} + {1'b0, r_discard}) == {1'b0, r_outstanding});
endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ============================================================================
// Module  : tb_fetch_queue
// Purpose : Scoreboard bench for fetch_queue with an in-order latency memory.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_queue;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready = 1'b0;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = '0;
   logic        dec_valid;
   logic [31:0] dec_pc;
   logic [31:0] dec_instr;
   logic        dec_ready = 1'b0;

   fetch_queue u_dut (
      .clk             (clk),
      .rst             (rst),
      .redirect        (redirect),
      .redirect_pc     (redirect_pc),
      .imem_req_valid  (imem_req_valid),
      .imem_req_addr   (imem_req_addr),
      .imem_req_ready  (imem_req_ready),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .dec_valid       (dec_valid),
      .dec_pc          (dec_pc),
      .dec_instr       (dec_instr),
      .dec_ready       (dec_ready)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          lat = 1;
   int          fires = 0;
   int          stream_next = 0;
   bit          chk_stream = 0;
   bit          prev_redirect = 0;
   bit          chk_disc_pending = 0;
   int          exp_disc = 0;
   logic        ctl_ready = 0;
   logic        ctl_dec_ready = 0;
   logic        ctl_redirect = 0;
   logic [31:0] ctl_redirect_pc = '0;
   logic [31:0] model_pc = '0;
   logic [31:0] sb_pc[$];
   logic [31:0] sb_instr[$];
   logic [31:0] memq_addr[$];
   int          memq_due[$];
   logic [31:0] delivered[$];

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return {~a[7:0], a[31:8]} ^ 32'h1357_9BDF;
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      redirect = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data = '0;
      imem_req_ready = 1'b0;
      dec_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check_eq("rst_req_valid", imem_req_valid, 0);
      check_eq("rst_dec_valid", dec_valid, 0);
      rst = 1'b0;
      sb_pc.delete(); sb_instr.delete();
      memq_addr.delete(); memq_due.delete();
      model_pc = '0; cyc = 0; fires = 0;
      prev_redirect = 0; chk_disc_pending = 0; ctl_redirect = 0;
      #1;
      check_eq("rst_req_valid_after", imem_req_valid, 1);
      check_eq("rst_req_addr", imem_req_addr, 32'h0);
      check_eq("rst_dec_pc", dec_pc, 32'h0);
      check_eq("rst_dec_instr", dec_instr, 32'h0);
   endtask

   // One clock cycle: entered and left at a negedge.
   task automatic step();
      logic [31:0] p;
      logic [31:0] ins;
      if (chk_disc_pending) begin
         check_eq("discard_after_redirect", u_dut.r_discard, exp_disc);
         chk_disc_pending = 0;
      end
      if (prev_redirect) check_eq("dec_valid_after_redirect", dec_valid, 0);
      if (memq_addr.size() > 0 && memq_due[0] <= cyc) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = instr_of(memq_addr[0]);
         void'(memq_addr.pop_front());
         void'(memq_due.pop_front());
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = '0;
      end
      redirect       = ctl_redirect;
      redirect_pc    = ctl_redirect_pc;
      imem_req_ready = ctl_ready;
      dec_ready      = ctl_dec_ready;
      #1;
      if (dec_valid && dec_ready) begin
         delivered.push_back(dec_pc);
         check_eq("sb_has_entry", sb_pc.size() > 0, 1);
         if (sb_pc.size() > 0) begin
            p   = sb_pc.pop_front();
            ins = sb_instr.pop_front();
            check_eq("dec_pc", dec_pc, p);
            check_eq("dec_instr", dec_instr, ins);
         end
         if (chk_stream) begin
            check_eq("stream_cycle", cyc, stream_next);
            stream_next++;
         end
      end
      if (redirect) check_eq("req_valid_in_redirect", imem_req_valid, 0);
      if (imem_req_valid && imem_req_ready) begin
         check_eq("req_addr", imem_req_addr, model_pc);
         memq_addr.push_back(imem_req_addr);
         memq_due.push_back(cyc + lat);
         sb_pc.push_back(model_pc);
         sb_instr.push_back(instr_of(model_pc));
         model_pc = model_pc + 32'd4;
         fires++;
      end
      if (redirect) begin
         sb_pc.delete(); sb_instr.delete();
         model_pc = ctl_redirect_pc & 32'hFFFF_FFFC;
         exp_disc = memq_addr.size();
         chk_disc_pending = 1;
         prev_redirect = 1;
         ctl_redirect = 0;
      end else begin
         prev_redirect = 0;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   initial begin
      // Streaming: one instruction per cycle from cycle 2
      do_reset();
      lat = 1; ctl_ready = 1; ctl_dec_ready = 1;
      chk_stream = 1; stream_next = 2; delivered.delete();
      repeat (12) step();
      chk_stream = 0;
      check_eq("stream_count", delivered.size(), 10);

      // Decode backpressure: occupancy bound stops issue at DEPTH
      do_reset();
      ctl_dec_ready = 0;
      repeat (10) step();
      check_eq("bp_fires", fires, 4);
      check_eq("bp_req_valid_off", imem_req_valid, 0);
      ctl_dec_ready = 1; delivered.delete();
      repeat (6) step();
      check_eq("bp_first", delivered[0], 32'h0);
      check_eq("bp_second", delivered[1], 32'h4);
      check_eq("bp_third", delivered[2], 32'h8);
      check_eq("bp_fourth", delivered[3], 32'hC);
      check_eq("bp_fifth", delivered[4], 32'h10);

      // Memory stall holds the request address
      do_reset();
      ctl_ready = 1; ctl_dec_ready = 1;
      repeat (2) step();
      ctl_ready = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         check_eq("stall_addr", imem_req_addr, 32'h8);
         check_eq("stall_fetch_pc", u_dut.r_fetch_pc, 32'h8);
      end
      ctl_ready = 1;
      step();
      check_eq("stall_advance", imem_req_addr, 32'hC);
      ctl_ready = 0;
      repeat (4) step();

      // Redirect with three requests in flight
      do_reset();
      lat = 4; ctl_ready = 1; ctl_dec_ready = 1;
      repeat (3) step();
      ctl_redirect = 1; ctl_redirect_pc = 32'h103;
      step();
      check_eq("redir_req_addr", imem_req_addr, 32'h100);
      delivered.delete();
      repeat (12) step();
      check_eq("redir_first_pc", delivered[0], 32'h100);

      // Redirect coincident with a response and a decode pop
      do_reset();
      lat = 2; ctl_ready = 1; ctl_dec_ready = 1;
      repeat (6) step();
      ctl_redirect = 1; ctl_redirect_pc = 32'h200;
      step();
      delivered.delete();
      repeat (8) step();
      check_eq("coinc_first_pc", delivered[0], 32'h200);

      // Address wrap at the top of the space
      lat = 1;
      ctl_redirect = 1; ctl_redirect_pc = 32'hFFFF_FFF8;
      step();
      delivered.delete();
      repeat (8) step();
      check_eq("wrap_0", delivered[0], 32'hFFFF_FFF8);
      check_eq("wrap_1", delivered[1], 32'hFFFF_FFFC);
      check_eq("wrap_2", delivered[2], 32'h0000_0000);
      check_eq("wrap_3", delivered[3], 32'h0000_0004);

      // Drain: every issued fetch must have been delivered
      ctl_ready = 0;
      repeat (10) step();
      check_eq("drain_sb_empty", sb_pc.size(), 0);
      check_eq("drain_mem_empty", memq_addr.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

`default_nettype wire
